// File: rtl/ad5662_spi_rx_pkg.sv
// Shared frame layout constants and state encoding for the AD5662-style SPI receiver.
package ad5662_spi_rx_pkg;

  localparam int unsigned AD5662_FRAME_BITS = 24;
  localparam int unsigned AD5662_PD_MSB     = 17;
  localparam int unsigned AD5662_PD_LSB     = 16;
  localparam int unsigned AD5662_DAT_MSB    = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/ad5662_spi_rx_sync.sv
// Multi-flop synchronizer for one asynchronous input; resets to a chosen idle level.
module ad5662_spi_rx_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (reset) ff <= {STAGES{RESET_VAL}};
    else       ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/ad5662_spi_rx.sv
// Receives 24-bit AD5662 write frames (MSB first, data on sclk falling edges)
// and presents the DAC code and power-down field with a one-cycle valid pulse.
module ad5662_spi_rx
  import ad5662_spi_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        sync_n,
  output logic [15:0] dat,
  output logic [1:0]  pd,
  output logic        valid,
  output logic        frame_err,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  localparam logic [4:0] LAST_CNT = 5'(AD5662_FRAME_BITS - 1);
  localparam logic [4:0] FULL_CNT = 5'(AD5662_FRAME_BITS);

  logic sclk_s, mosi_s, sync_s;
  logic sclk_h, mosi_h, sync_h;
  logic sclk_fall, sync_fall, sync_rise;
  logic [SYNC_STAGES:0] flush;
  logic armed;
  state_t state;
  logic [4:0] cnt;
  // The six leading don't-care bits simply fall off the top of the register.
  logic [AD5662_PD_MSB:0] sr;

  ad5662_spi_rx_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .d(sclk), .q(sclk_s)
  );
  ad5662_spi_rx_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .d(mosi), .q(mosi_s)
  );
  ad5662_spi_rx_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sync_n (
    .clk(clk), .reset(reset), .d(sync_n), .q(sync_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_h <= 1'b0;
      mosi_h <= 1'b0;
      sync_h <= 1'b1;
    end else begin
      sclk_h <= sclk_s;
      mosi_h <= mosi_s;
      sync_h <= sync_s;
    end
  end

  assign sclk_fall = sclk_h & ~sclk_s;
  assign sync_fall = sync_h & ~sync_s;
  assign sync_rise = ~sync_h & sync_s;

  // After reset the synchronizer holds a fake idle-high level; a frame is only
  // armed once the real pin has been seen high, so an in-progress frame is skipped.
  always_ff @(posedge clk) begin
    if (reset) begin
      flush <= '0;
      armed <= 1'b0;
    end else begin
      flush <= {flush[SYNC_STAGES-1:0], 1'b1};
      if (flush[SYNC_STAGES] && sync_s) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      cnt       <= '0;
      sr        <= '0;
      dat       <= '0;
      pd        <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (armed && sync_fall) begin
            state <= SHIFT;
            busy  <= 1'b1;
            cnt   <= '0;
            sr    <= '0;
          end
        end
        SHIFT: begin
          if (cnt == FULL_CNT) begin
            dat       <= sr[AD5662_DAT_MSB:0];
            pd        <= sr[AD5662_PD_MSB:AD5662_PD_LSB];
            valid     <= 1'b1;
            frame_cnt <= frame_cnt + 16'd1;
            // sync_n may already have risen together with the last bit.
            if (sync_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= HOLD;
            end
          end else begin
            if (sclk_fall) begin
              sr  <= {sr[AD5662_PD_MSB-1:0], mosi_h};
              cnt <= cnt + 5'd1;
            end
            if (sync_rise && !(sclk_fall && cnt == LAST_CNT)) begin
              frame_err <= 1'b1;
              state     <= IDLE;
              busy      <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (sync_rise) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ad5662_spi_rx.sv
// Directed, table-driven bench for ad5662_spi_rx with hand-computed expectations.
module tb_ad5662_spi_rx;

  localparam int unsigned S = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        sync_n = 1'b1;
  logic [15:0] dat;
  logic [1:0]  pd;
  logic        valid;
  logic        frame_err;
  logic        busy;
  logic [15:0] frame_cnt;

  ad5662_spi_rx #(.SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .sync_n(sync_n),
    .dat(dat), .pd(pd), .valid(valid), .frame_err(frame_err),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int overlap = 0;
  int longp = 0;
  int last_valid_cyc = 0;
  int fall24_cyc = 0;
  logic busy_mid = 1'b0;
  logic prev_valid = 1'b0;
  logic prev_err = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      last_valid_cyc = cyc;
    end
    if (frame_err) n_err++;
    if (valid && frame_err) overlap++;
    if ((valid && prev_valid) || (frame_err && prev_err)) longp++;
    prev_valid = valid;
    prev_err   = frame_err;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // sclk = clk/8; mosi set on the rising phase so it is stable at the fall.
  task automatic clock_bits(input logic [23:0] w, input int nbits, input bit coincide);
    for (int i = 0; i < nbits; i++) begin
      if (i < 24) mosi = w[23-i];
      else        mosi = 1'b1;
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
      if (coincide && i == nbits - 1) sync_n = 1'b1;
      if (i == 23) fall24_cyc = cyc;
      if (i == nbits / 2) busy_mid = busy;
      tick(4);
    end
  endtask

  task automatic send_frame(input logic [23:0] w, input int nbits, input bit coincide);
    sync_n = 1'b0;
    tick(4);
    clock_bits(w, nbits, coincide);
    sync_n = 1'b1;
    tick(12);
  endtask

  typedef struct {
    logic [23:0] word;
    int          nbits;
    logic [15:0] exp_dat;
    logic [1:0]  exp_pd;
    int          exp_v;
    int          exp_e;
  } vec_t;

  vec_t vecs[6];
  int exp_cnt = 0;
  int v0, e0;

  task automatic check_frame(input string tag, input logic [15:0] ed, input logic [1:0] ep,
                             input int ev, input int ee);
    chk({tag, "_valid_pulses"}, 32'(n_valid - v0), 32'(ev));
    chk({tag, "_err_pulses"}, 32'(n_err - e0), 32'(ee));
    chk({tag, "_dat"}, 32'(dat), 32'(ed));
    chk({tag, "_pd"}, 32'(pd), 32'(ep));
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{24'h00_7FFF, 24, 16'h7FFF, 2'b00, 1, 0};
    vecs[1] = '{24'hFF_FFFF, 24, 16'hFFFF, 2'b11, 1, 0};
    vecs[2] = '{24'h03_0000, 24, 16'h0000, 2'b11, 1, 0};
    vecs[3] = '{24'h00_5555, 10, 16'h0000, 2'b11, 0, 1};
    vecs[4] = '{24'h00_1234, 24, 16'h1234, 2'b00, 1, 0};
    vecs[5] = '{24'h00_ABCD, 29, 16'hABCD, 2'b00, 1, 0};

    tick(3);
    chk("rst_dat", 32'(dat), 32'd0);
    chk("rst_pd", 32'(pd), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    reset = 1'b0;
    tick(10);

    for (int k = 0; k < 6; k++) begin
      v0 = n_valid;
      e0 = n_err;
      send_frame(vecs[k].word, vecs[k].nbits, 1'b0);
      exp_cnt += vecs[k].exp_v;
      check_frame($sformatf("vec%0d", k), vecs[k].exp_dat, vecs[k].exp_pd,
                  vecs[k].exp_v, vecs[k].exp_e);
      chk($sformatf("vec%0d_busy_mid", k), 32'(busy_mid), 32'd1);
      if (vecs[k].exp_v != 0)
        chk($sformatf("vec%0d_latency", k), 32'(last_valid_cyc - fall24_cyc), 32'(S + 2));
    end

    // sync_n rises in the same cycle as the 24th sclk fall: still accepted.
    v0 = n_valid;
    e0 = n_err;
    send_frame(24'h00_0F0F, 24, 1'b1);
    exp_cnt++;
    check_frame("coincide", 16'h0F0F, 2'b00, 1, 0);
    chk("coincide_latency", 32'(last_valid_cyc - fall24_cyc), 32'(S + 2));
    v0 = n_valid;
    e0 = n_err;
    send_frame(24'h02_4242, 24, 1'b0);
    exp_cnt++;
    check_frame("after_coincide", 16'h4242, 2'b10, 1, 0);

    // Reset in the middle of a frame; the tail of that frame must be ignored.
    v0 = n_valid;
    e0 = n_err;
    sync_n = 1'b0;
    tick(4);
    clock_bits(24'h01_F0F0, 12, 1'b0);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    clock_bits(24'hFF_FFFF, 12, 1'b0);
    sync_n = 1'b1;
    tick(12);
    exp_cnt = 0;
    check_frame("midreset", 16'h0000, 2'b00, 0, 0);
    send_frame(24'h00_8000, 24, 1'b0);
    exp_cnt = 1;
    check_frame("post_reset", 16'h8000, 2'b00, 1, 0);

    // frame_cnt wrap
    force dut.frame_cnt = 16'hFFFF;
    tick(1);
    release dut.frame_cnt;
    tick(1);
    chk("wrap_preload", 32'(frame_cnt), 32'h0000_FFFF);
    v0 = n_valid;
    e0 = n_err;
    send_frame(24'h00_0001, 24, 1'b0);
    exp_cnt = 0;
    check_frame("wrap", 16'h0001, 2'b00, 1, 0);

    chk("valid_err_overlap", 32'(overlap), 32'd0);
    chk("pulse_too_long", 32'(longp), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
